// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 inverse-cipher sequencing logic.
package aes_pkg;

   localparam int unsigned NUM_ROUNDS     = 10;
   localparam int unsigned KEY_EXP_CYCLES = NUM_ROUNDS + 1;

   localparam logic [3:0] LAST_KEY_IDX = 4'(KEY_EXP_CYCLES - 1);
   localparam logic [3:0] FIRST_RK     = 4'(NUM_ROUNDS);
   localparam logic [3:0] FIRST_ROUND  = 4'(NUM_ROUNDS - 1);

   localparam logic [1:0] STEP_ADDKEY  = 2'b00;
   localparam logic [1:0] STEP_INVSRSB = 2'b01;
   localparam logic [1:0] STEP_INVMIX  = 2'b10;
   localparam logic [1:0] STEP_HOLD    = 2'b11;

   typedef enum logic [2:0] {
      StIdle,
      StKeyExp,
      StInitAdd,
      StInvSrsb,
      StAddKey,
      StInvMix,
      StDone
   } state_e;

endpackage

// File: rtl/key_cache_flags.sv
// Tracks whether the key store holds a usable expansion of the current key.
module key_cache_flags (
   input  logic clk,
   input  logic n_rst,
   input  logic key_change,
   input  logic exp_start,
   input  logic exp_finish,
   input  logic exp_abort,
   output logic key_valid,
   output logic key_dirty
);

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         key_valid <= 1'b0;
         key_dirty <= 1'b1;
      end else begin
         if (exp_abort) begin
            key_valid <= 1'b0;
         end else if (exp_finish) begin
            key_valid <= 1'b1;
         end
         // Dirty is cleared when expansion begins, so a change seen mid-expansion survives.
         if (key_change) begin
            key_dirty <= 1'b1;
         end else if (exp_start) begin
            key_dirty <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/decryption_round_scheduler.sv
// Control sequencer for the AES-128 inverse cipher: key expansion, initial
// AddRoundKey, then InvShiftRows/InvSubBytes, AddRoundKey, InvMixColumns rounds.
module decryption_round_scheduler
   import aes_pkg::*;
(
   input  logic       clk,
   input  logic       n_rst,
   input  logic       decryptEnable,
   input  logic       key_change,
   input  logic       abort,
   output logic       busy,
   output logic       done,
   output logic       out_valid,
   output logic       key_exp_en,
   output logic [3:0] key_idx,
   output logic [3:0] rk_sel,
   output logic       load_data,
   output logic [1:0] step_sel,
   output logic       state_en
);

   state_e     state_q, state_d;
   logic [3:0] round_q, round_d;
   logic [3:0] key_idx_q, key_idx_d;
   logic       out_valid_q, out_valid_d;
   logic       exp_start, exp_finish, exp_abort;
   logic       key_valid, key_dirty;

   key_cache_flags u_key_cache_flags (
      .clk        (clk),
      .n_rst      (n_rst),
      .key_change (key_change),
      .exp_start  (exp_start),
      .exp_finish (exp_finish),
      .exp_abort  (exp_abort),
      .key_valid  (key_valid),
      .key_dirty  (key_dirty)
   );

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q     <= StIdle;
         round_q     <= 4'd0;
         key_idx_q   <= 4'd0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         round_q     <= round_d;
         key_idx_q   <= key_idx_d;
         out_valid_q <= out_valid_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      round_d     = round_q;
      key_idx_d   = key_idx_q;
      out_valid_d = out_valid_q;
      exp_start   = 1'b0;
      exp_finish  = 1'b0;
      exp_abort   = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      key_exp_en  = 1'b0;
      key_idx     = 4'd0;
      rk_sel      = 4'd0;
      load_data   = 1'b0;
      step_sel    = STEP_HOLD;
      state_en    = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (decryptEnable) begin
               out_valid_d = 1'b0;
               if (key_valid && !key_dirty) begin
                  state_d = StInitAdd;
               end else begin
                  state_d   = StKeyExp;
                  key_idx_d = 4'd0;
                  exp_start = 1'b1;
               end
            end
         end
         StKeyExp: begin
            busy       = 1'b1;
            key_exp_en = 1'b1;
            key_idx    = key_idx_q;
            if (key_idx_q == LAST_KEY_IDX) begin
               exp_finish = 1'b1;
               key_idx_d  = 4'd0;
               state_d    = StInitAdd;
            end else begin
               key_idx_d = key_idx_q + 4'd1;
            end
         end
         StInitAdd: begin
            busy      = 1'b1;
            load_data = 1'b1;
            state_en  = 1'b1;
            rk_sel    = FIRST_RK;
            step_sel  = STEP_ADDKEY;
            round_d   = FIRST_ROUND;
            state_d   = StInvSrsb;
         end
         StInvSrsb: begin
            busy     = 1'b1;
            step_sel = STEP_INVSRSB;
            state_en = 1'b1;
            state_d  = StAddKey;
         end
         StAddKey: begin
            busy     = 1'b1;
            step_sel = STEP_ADDKEY;
            rk_sel   = round_q;
            state_en = 1'b1;
            // Zero test comes before any decrement, so round never wraps.
            if (round_q == 4'd0) begin
               out_valid_d = 1'b1;
               state_d     = StDone;
            end else begin
               state_d = StInvMix;
            end
         end
         StInvMix: begin
            busy     = 1'b1;
            step_sel = STEP_INVMIX;
            state_en = 1'b1;
            round_d  = round_q - 4'd1;
            state_d  = StInvSrsb;
         end
         StDone: begin
            done    = 1'b1;
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if (abort) begin
         state_d     = StIdle;
         out_valid_d = 1'b0;
         key_idx_d   = 4'd0;
         exp_start   = 1'b0;
         exp_finish  = 1'b0;
         exp_abort   = (state_q == StKeyExp);
      end
   end

   assign out_valid = out_valid_q;

endmodule
